// File: rtl/mp_ooo_data_array_arbiter.sv
// Two-port arbiter for the single-port byte-masked data array, with one response slot per port.
// Optional DATA_ARB_RR_EN selects round-robin arbitration instead of fixed port-0 priority.
module mp_ooo_data_array_arbiter #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_WMASKS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [NUM_WMASKS-1:0] p0_req_wmask,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_resp_valid,
   input  logic                  p0_resp_ready,
   output logic [DATA_WIDTH-1:0] p0_resp_rdata,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [NUM_WMASKS-1:0] p1_req_wmask,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_resp_valid,
   input  logic                  p1_resp_ready,
   output logic [DATA_WIDTH-1:0] p1_resp_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   logic                  inflight_q, inflight_d;
   logic                  inflight_port_q, inflight_port_d;
   logic                  p0_resp_valid_q, p0_resp_valid_d;
   logic                  p1_resp_valid_q, p1_resp_valid_d;
   logic [DATA_WIDTH-1:0] p0_resp_rdata_q, p0_resp_rdata_d;
   logic [DATA_WIDTH-1:0] p1_resp_rdata_q, p1_resp_rdata_d;
   logic                  p0_elig, p1_elig, cand0, cand1, gnt0, gnt1;
`ifdef DATA_ARB_RR_EN
   logic                  rr_q, rr_d;
`endif

   always_comb begin
      // A read needs its port idle: nothing in flight for it and a slot that is free or draining.
      p0_elig = p0_req_we | (~(inflight_q & ~inflight_port_q) &
                             (~p0_resp_valid_q | p0_resp_ready));
      p1_elig = p1_req_we | (~(inflight_q & inflight_port_q) &
                             (~p1_resp_valid_q | p1_resp_ready));
      cand0   = rst_n & p0_req_valid & p0_elig;
      cand1   = rst_n & p1_req_valid & p1_elig;
`ifdef DATA_ARB_RR_EN
      gnt0    = cand0 & (~cand1 | rr_q);
      gnt1    = cand1 & (~cand0 | ~rr_q);
      rr_d    = (gnt0 | gnt1) ? gnt1 : rr_q;
`else
      gnt0    = cand0;
      gnt1    = cand1 & ~cand0;
`endif
      p0_req_ready = gnt0;
      p1_req_ready = gnt1;

      sram_csb = ~(gnt0 | gnt1);
      if (gnt1) begin
         sram_web   = ~p1_req_we;
         sram_wmask = p1_req_we ? p1_req_wmask : '0;
         sram_addr  = p1_req_addr;
         sram_din   = p1_req_wdata;
      end else begin
         sram_web   = ~p0_req_we;
         sram_wmask = p0_req_we ? p0_req_wmask : '0;
         sram_addr  = p0_req_addr;
         sram_din   = p0_req_wdata;
      end

      inflight_d      = (gnt0 & ~p0_req_we) | (gnt1 & ~p1_req_we);
      inflight_port_d = gnt1;

      p0_resp_valid_d = p0_resp_valid_q & ~p0_resp_ready;
      p0_resp_rdata_d = p0_resp_rdata_q;
      p1_resp_valid_d = p1_resp_valid_q & ~p1_resp_ready;
      p1_resp_rdata_d = p1_resp_rdata_q;
      if (inflight_q & ~inflight_port_q) begin
         p0_resp_valid_d = 1'b1;
         p0_resp_rdata_d = sram_dout;
      end
      if (inflight_q & inflight_port_q) begin
         p1_resp_valid_d = 1'b1;
         p1_resp_rdata_d = sram_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q      <= 1'b0;
         inflight_port_q <= 1'b0;
         p0_resp_valid_q <= 1'b0;
         p1_resp_valid_q <= 1'b0;
         p0_resp_rdata_q <= '0;
         p1_resp_rdata_q <= '0;
`ifdef DATA_ARB_RR_EN
         rr_q            <= 1'b1;
`endif
      end else begin
         inflight_q      <= inflight_d;
         inflight_port_q <= inflight_port_d;
         p0_resp_valid_q <= p0_resp_valid_d;
         p1_resp_valid_q <= p1_resp_valid_d;
         p0_resp_rdata_q <= p0_resp_rdata_d;
         p1_resp_rdata_q <= p1_resp_rdata_d;
`ifdef DATA_ARB_RR_EN
         rr_q            <= rr_d;
`endif
      end
   end

   assign p0_resp_valid = p0_resp_valid_q;
   assign p1_resp_valid = p1_resp_valid_q;
   assign p0_resp_rdata = p0_resp_rdata_q;
   assign p1_resp_rdata = p1_resp_rdata_q;

endmodule
